// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared stage indices, bundle field map and helpers for ctrl_pipe
package ctrl_pipe_pkg;

    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    localparam int MAX_STAGES = 8;
    localparam int BUNDLE_W   = 16;
    localparam int PERF_W     = 32;

    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Control bundle field map: offset / width
    localparam int MEMTOREG_OFF   = 0;
    localparam int MEMTOREG_W     = 1;
    localparam int MEMWRITE_OFF   = 1;
    localparam int MEMWRITE_W     = 1;
    localparam int ALUSRC_OFF     = 2;
    localparam int ALUSRC_W       = 1;
    localparam int REGDST_OFF     = 3;
    localparam int REGDST_W       = 2;
    localparam int REGWRITE_OFF   = 5;
    localparam int REGWRITE_W     = 1;
    localparam int ALUCTRL_OFF    = 6;
    localparam int ALUCTRL_W      = 5;
    localparam int HILO_WRITE_OFF = 11;
    localparam int HILO_WRITE_W   = 1;
    localparam int JAL_OFF        = 12;
    localparam int JAL_W          = 1;
    localparam int CP0_WRITE_OFF  = 13;
    localparam int CP0_WRITE_W    = 1;
    localparam int IS_INVALID_OFF = 14;
    localparam int IS_INVALID_W   = 1;

    // Stage-k bundle out of a flattened out_ctrl (zero-extend narrower buses into flat)
    function automatic logic [BUNDLE_W-1:0] stage_ctrl(
        input logic [MAX_STAGES*BUNDLE_W-1:0] flat,
        input int unsigned                    k
    );
        return flat[k*BUNDLE_W +: BUNDLE_W];
    endfunction

    // A legal stall vector is a run of ones from bit 0 upward
    function automatic logic stall_is_monotonic(input logic [MAX_STAGES-1:0] s);
        for (int i = 1; i < MAX_STAGES; i++) begin
            if (s[i] && !s[i-1]) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - decode-side inputs and per-stage outputs of ctrl_pipe
interface ctrl_pipe_if
    import ctrl_pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int STAGES = 3
);
    logic                       in_valid;
    logic [CTRL_W-1:0]          in_ctrl;
    logic [STAGES-1:0]          stall;
    logic [STAGES-1:0]          flush;
    logic                       exc_flush;
    logic [STAGES-1:0]          out_valid;
    logic [STAGES*CTRL_W-1:0]   out_ctrl;
    logic [STAGES*PERF_W-1:0]   perf_bubble_cnt;

    modport master (
        output in_valid, in_ctrl, stall, flush, exc_flush,
        input  out_valid, out_ctrl, perf_bubble_cnt
    );

    modport slave (
        input  in_valid, in_ctrl, stall, flush, exc_flush,
        output out_valid, out_ctrl, perf_bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one valid+ctrl pipeline register with optional CTRL_PIPE_PERF_EN bubble counter
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                src_valid,
    input  logic [CTRL_W-1:0]   src_ctrl,
    input  logic                stall,
    input  logic                up_stall,
    input  logic                clear,
    output logic                valid,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [PERF_W-1:0]   bubble_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (stall) begin
            valid <= valid;
            ctrl  <= ctrl;
        end else if (up_stall) begin
            // Upstream is holding its instruction; passing it on too would duplicate it
            valid <= 1'b0;
            ctrl  <= '0;
        end else begin
            valid <= src_valid;
            ctrl  <= src_valid ? src_ctrl : '0;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic              cnt_event;
    logic [PERF_W-1:0] cnt;

    assign cnt_event = (clear && valid) || (!clear && !stall && up_stall);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_event && (cnt != PERF_MAX)) begin
            cnt <= cnt + PERF_W'(1);
        end
    end

    assign bubble_cnt = cnt;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - STAGES-deep control-bundle pipeline, perf counters under CTRL_PIPE_PERF_EN
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int                CTRL_W   = 16,
    parameter int                STAGES   = 3,
    parameter logic [STAGES-1:0] EXC_MASK = STAGES'(3'b011)
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    logic [STAGES-1:0] stg_valid;
    logic [CTRL_W-1:0] stg_ctrl [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              src_valid;
        logic [CTRL_W-1:0] src_ctrl;
        logic              up_stall;
        logic              clear;
        logic [PERF_W-1:0] cnt;

        if (k == 0) begin : g_head
            assign src_valid = bus.in_valid;
            assign src_ctrl  = bus.in_ctrl;
            assign up_stall  = 1'b0;
        end else begin : g_body
            assign src_valid = stg_valid[k-1];
            assign src_ctrl  = stg_ctrl[k-1];
            assign up_stall  = bus.stall[k-1];
        end

        assign clear = bus.flush[k] | (bus.exc_flush & EXC_MASK[k]);

        ctrl_pipe_stage #(
            .CTRL_W (CTRL_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .src_valid  (src_valid),
            .src_ctrl   (src_ctrl),
            .stall      (bus.stall[k]),
            .up_stall   (up_stall),
            .clear      (clear),
            .valid      (stg_valid[k]),
            .ctrl       (stg_ctrl[k]),
            .bubble_cnt (cnt)
        );

        assign bus.out_ctrl[k*CTRL_W +: CTRL_W]        = stg_ctrl[k];
        assign bus.perf_bubble_cnt[k*PERF_W +: PERF_W] = cnt;
    end

    assign bus.out_valid = stg_valid;

    a_stall_monotonic: assert property (
        @(posedge clk) disable iff (!rst) stall_is_monotonic(MAX_STAGES'(bus.stall))
    );

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Generic, parametrised control-bundle pipeline. Carries decoded control words from decode through STAGES downstream pipeline registers (default E, M, W).
- Each stage has its own stall and flush, an explicit valid bit, automatic bubble insertion, and a masked exception flush.
- Replaces the hand-wired fixed-width per-stage flop chains in the controller. Downstream stages tap bundle fields by offset.

Parameters:
- CTRL_W, 16, width of the control bundle entering stage 0.
- STAGES, 3, number of pipeline stages (index 0 = E, 1 = M, 2 = W); legal range 1..8.
- EXC_MASK, 3'b011, bit k = 1 means stage k is cleared by exc_flush; width STAGES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decode-stage bundle is a real instruction.
- in_ctrl  in  CTRL_W  decode-stage control bundle.
- stall  in  STAGES  per-stage hold; bit k holds stage k.
- flush  in  STAGES  per-stage synchronous clear; bit k clears stage k.
- exc_flush  in  1  exception/eret redirect; clears every stage whose EXC_MASK bit is 1.
- out_valid  out  STAGES  valid bit of each stage register.
- out_ctrl  out  STAGES*CTRL_W  stage k bundle at bits [k*CTRL_W +: CTRL_W].
- perf_bubble_cnt  out  STAGES*32  per-stage bubble-cycle counters (optional feature).

Behaviour:
- Reset: rst = 0 asynchronously forces every out_valid and out_ctrl bit to 0, and every counter to 0. Release is synchronous to clk.
- Latency: an unstalled bundle sampled at edge n appears on stage 0 after edge n. It appears on stage k after edge n+k.
- Per-stage next-state, in priority order, for stage k:
  1. flush[k] = 1, or (exc_flush = 1 and EXC_MASK[k] = 1): valid <= 0, ctrl <= 0.
  2. stall[k] = 1: hold.
  3. k > 0 and stall[k-1] = 1: bubble, valid <= 0, ctrl <= 0. The upstream stage holds its instruction, so it must not be duplicated.
  4. Otherwise: load from the source. The source for stage 0 is in_valid/in_ctrl; for stage k it is stage k-1.
- Invariant: out_ctrl of any stage with out_valid = 0 is all zeros. Downstream regwrite/memwrite/hilo_write decode is therefore safe without gating.
- Decode-side stall: a stage-0 load with in_valid = 0 stores ctrl = 0, even if in_ctrl is nonzero.
- Flush beats stall on the same stage in the same cycle.
- Stall monotonicity is required of the hazard unit: stall[k] = 1 implies stall[j] = 1 for all j < k. A non-monotonic vector is flagged by a simulation-only assertion. RTL behaviour is still defined by the rules above.
- Simultaneous flush[k] and load into stage k+1: stage k+1 captures the pre-flush stage-k contents. Ordinary register semantics apply.
- Reset asserted mid-operation drops all in-flight bundles. There is no drain.
- Fully synchronous except rst. No combinational path from any input to out_valid or out_ctrl.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- With the macro defined:
  - Stage k's 32-bit counter increments on each clock edge where stage k loads a bubble (rule 3) or is flushed while valid.
  - Counters saturate at 32'hFFFF_FFFF and are cleared only by rst.
- Without the macro:
  - perf_bubble_cnt is tied to 0 and no counter flops are synthesised.
  - The port stays present, so instantiations are identical either way.

Decomposition:
- Shared package ctrl_pipe_pkg holds:
  - stage index constants STG_E = 0, STG_M = 1, STG_W = 2;
  - bundle field offset/width localparams (MEMTOREG, MEMWRITE, ALUSRC, REGDST[1:0], REGWRITE, ALUCTRL[4:0], HILO_WRITE, JAL, CP0_WRITE, IS_INVALID);
  - a function returning the stage-k slice of out_ctrl.
- One natural sub-module, ctrl_pipe_stage: a single valid+ctrl register implementing the priority rules, plus its perf counter. ctrl_pipe instantiates it STAGES times with a generate loop.

Test Plan:
- Reset: hold rst = 0 with in_valid = 1 and in_ctrl = 16'hFFFF. Required: out_valid = 0 and out_ctrl = 0 throughout. After release, in_ctrl = 16'h1234 appears on E at +1 cycle, on M at +2, and on W at +3, with valid = 1 in each.
- Bubble: stall = 3'b001 for 2 cycles with A in E. Required: E holds A; M receives two bubbles (valid = 0, ctrl = 0); A reaches M one cycle after the stall drops.
- Flush vs stall: set stall[1] = 1 and flush[1] = 1 together with B in M. Required: M is cleared (valid = 0) and B is lost.
- Exception: exc_flush = 1 with EXC_MASK = 3'b011 and valid C/D/E in E/M/W. Required: E and M are cleared; W keeps E and retires.
- Decode stall: in_valid = 0 with in_ctrl = 16'hABCD. Required: E loads ctrl = 0 and valid = 0.
- Perf counters (CTRL_PIPE_PERF_EN defined): stall[0] held for 5 cycles. Required: perf_bubble_cnt for M reads 5 and E reads 0. Without the macro, all counters read 0.
